uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding.
// Used by the receiver (uart_rx) and intended to be shared with the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 8;
  localparam int START_CHECK = 7;
  localparam int DATA_BITS   = 8;

  localparam logic [3:0] SMP_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SMP_CHK  = 4'(START_CHECK);
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input.
// Ports: i_clk, i_rst (sync, active-high), i_rst_val (reset level), i_d (async in), o_q (synced out).
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= i_rst_val;
      r_sync <= i_rst_val;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled via CLK_EN strobe, sticky RDY.
// Ports: CLK, RST (sync, active-high), RX (async line), CLK_EN (16x strobe),
//   RDY_CLR (clears RDY/FERR), DOUT (last byte), RDY, RX_BUSY,
//   FERR (stop-bit error, only when UART_RX_FERR_EN is defined).
module uart_rx
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic       CLK_EN,
  input  logic       RDY_CLR,
  output logic [7:0] DOUT,
  output logic       RDY,
  output logic       RX_BUSY
`ifdef UART_RX_FERR_EN
  ,
  output logic       FERR
`endif
);

  logic        w_rx_s;

  uart_state_t r_state, w_state_nx;
  logic [3:0]  r_sample, w_sample_nx;
  logic [2:0]  r_bitpos, w_bitpos_nx;
  logic [7:0]  r_scratch, w_scratch_nx;
  logic [7:0]  r_dout, w_dout_nx;
  logic        r_rdy, w_rdy_nx;
  logic        w_done;

  uart_sync2 u_sync (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_rst_val (1'b1),
    .i_d       (RX),
    .o_q       (w_rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_sample  <= 4'd0;
      r_bitpos  <= 3'd0;
      r_scratch <= 8'h00;
      r_dout    <= 8'h00;
      r_rdy     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sample  <= w_sample_nx;
      r_bitpos  <= w_bitpos_nx;
      r_scratch <= w_scratch_nx;
      r_dout    <= w_dout_nx;
      r_rdy     <= w_rdy_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_sample_nx  = r_sample;
    w_bitpos_nx  = r_bitpos;
    w_scratch_nx = r_scratch;
    w_dout_nx    = r_dout;
    w_done       = 1'b0;
    if (CLK_EN) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            w_sample_nx = 4'd1;
            w_state_nx  = ST_START;
          end
        end
        ST_START: begin
          w_sample_nx = r_sample + 4'd1;
          // line back high at mid-start: a glitch, not a frame
          if (r_sample == SMP_CHK && w_rx_s) begin
            w_state_nx = ST_IDLE;
          end else if (r_sample == SMP_LAST) begin
            w_sample_nx = 4'd0;
            w_bitpos_nx = 3'd0;
            w_state_nx  = ST_DATA;
          end
        end
        ST_DATA: begin
          w_sample_nx = r_sample + 4'd1;
          if (r_sample == SMP_MID) begin
            w_scratch_nx[r_bitpos] = w_rx_s;
          end
          if (r_sample == SMP_LAST) begin
            if (r_bitpos == BIT_LAST) begin
              w_sample_nx = 4'd0;
              w_state_nx  = ST_STOP;
            end else begin
              w_bitpos_nx = r_bitpos + 3'd1;
            end
          end
        end
        ST_STOP: begin
          w_sample_nx = r_sample + 4'd1;
          // leave at mid-stop so a back-to-back start edge is seen
          if (r_sample == SMP_MID) begin
            w_done     = 1'b1;
            w_dout_nx  = r_scratch;
            w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // byte completion beats a coincident clear
  assign w_rdy_nx = w_done | (r_rdy & ~RDY_CLR);

  assign DOUT    = r_dout;
  assign RDY     = r_rdy;
  assign RX_BUSY = (r_state != ST_IDLE);

`ifdef UART_RX_FERR_EN
  logic r_ferr;
  logic w_ferr_nx;

  assign w_ferr_nx = w_done ? ~w_rx_s : (r_ferr & ~RDY_CLR);

  always_ff @(posedge CLK) begin
    if (RST) r_ferr <= 1'b0;
    else     r_ferr <= w_ferr_nx;
  end

  assign FERR = r_ferr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Drives 8N1 frames at 16 CLK_EN ticks per bit, one tick every 4 clocks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       clk_en = 1'b0;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy;
  logic       busy;
`ifdef UART_RX_FERR_EN
  logic       ferr;
`endif

  int n_chk = 0;
  int n_pass = 0;

  uart_rx dut (
    .CLK     (clk),
    .RST     (rst),
    .RX      (rx),
    .CLK_EN  (clk_en),
    .RDY_CLR (rdy_clr),
    .DOUT    (dout),
    .RDY     (rdy),
    .RX_BUSY (busy)
`ifdef UART_RX_FERR_EN
    ,
    .FERR    (ferr)
`endif
  );

  always #5 clk = ~clk;

  initial begin : en_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      clk_en = (cnt % 4 == 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance to just after the next CLK_EN edge; optionally pulse RDY_CLR on it
  task automatic tick(input bit clr);
    do begin
      @(negedge clk);
      #1;
    end while (!clk_en);
    rdy_clr = clr;
    @(posedge clk);
    #1;
    rdy_clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // k indexes CLK_EN ticks from the start-detect tick (k=0);
  // byte completes on k=152, i.e. the 153rd tick counting the detect tick
  task automatic send_frame(input logic [7:0] d, input bit stop_b,
                            input bit clr_at_done, input bit chk_lat,
                            input int abort_at);
    for (int k = 0; k < 160; k++) begin
      if (k == abort_at) return;
      if (k < 16)       rx = 1'b0;
      else if (k < 144) rx = d[(k - 16) >> 4];
      else if (k <= 152) rx = stop_b;
      else              rx = 1'b1;
      tick(clr_at_done && (k == 152));
      if (k == 0) chk("busy_start", {31'd0, busy}, 32'd1);
      if (chk_lat && k == 151) chk("rdy_early", {31'd0, rdy}, 32'd0);
      if (k == 152) begin
        chk("rdy_done", {31'd0, rdy}, 32'd1);
        chk("dout", {24'd0, dout}, {24'd0, d});
        chk("busy_done", {31'd0, busy}, 32'd0);
      end
    end
    rx = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, {24'd0, dout}, 32'h00);
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef UART_RX_FERR_EN
    chk({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset");
    ticks(3);

    // single byte with latency check
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    ticks(4);
    chk("a5_hold", {24'd0, dout}, 32'hA5);
    tick(1'b1);
    chk("rdy_clr", {31'd0, rdy}, 32'd0);

    // glitch rejection
    rx = 1'b0;
    tick(1'b0);
    chk("busy_glitch", {31'd0, busy}, 32'd1);
    ticks(3);
    rx = 1'b1;
    ticks(12);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_rdy", {31'd0, rdy}, 32'd0);
    chk("glitch_dout", {24'd0, dout}, 32'hA5);

    // back-to-back, overrun without clearing
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1);
    ticks(4);
    chk("b2b_dout", {24'd0, dout}, 32'hFF);
    chk("b2b_rdy", {31'd0, rdy}, 32'd1);

    // set beats clear on the completion edge
    tick(1'b1);
    chk("pre_coll_rdy", {31'd0, rdy}, 32'd0);
    send_frame(8'h96, 1'b1, 1'b1, 1'b1, -1);
    ticks(2);
    chk("coll_rdy", {31'd0, rdy}, 32'd1);
    tick(1'b1);
    chk("coll_clr", {31'd0, rdy}, 32'd0);

    // stop bit low
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    ticks(4);
    chk("bad_stop_busy", {31'd0, busy}, 32'd0);
`ifdef UART_RX_FERR_EN
    chk("ferr_set", {31'd0, ferr}, 32'd1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
    ticks(2);
    chk("ferr_good", {31'd0, ferr}, 32'd0);
    chk("ferr_good_dout", {24'd0, dout}, 32'h81);
`endif
    tick(1'b1);

    // reset during data bit 4
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 16 + 4 * 16 + 5);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("midrst");
    ticks(3);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, -1);
    ticks(2);
    chk("final_dout", {24'd0, dout}, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
